lookahead_borrow_subtractor: RTL and testbench
==============================================

LOOKAHEAD_BORROW_SUBTRACTOR -- requirements
Module: lookahead_borrow_subtractor

Interface
REQ-001 Parameter WIDTH, default 16: operand/result width in bits.
REQ-002 Parameter CHUNK, default 4: bits resolved per cycle by one borrow-lookahead slice.
REQ-003 clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset, asynchronous and active-high.
REQ-005 in_valid  input  1  operands a, b, b_i valid this cycle.
REQ-006 in_ready  output  1  block can accept operands.
REQ-007 a  input  WIDTH  minuend.
REQ-008 b  input  WIDTH  subtrahend.
REQ-009 b_i  input  1  borrow-in.
REQ-010 out_valid  output  1  d, b_o, zero hold a valid result.
REQ-011 out_ready  input  1  consumer takes the result.
REQ-012 d  output  WIDTH  difference a - b - b_i, modulo 2^WIDTH.
REQ-013 b_o  output  1  borrow-out; 1 when a < b + b_i (unsigned).
REQ-014 zero  output  1  1 when d == 0.

Function
REQ-015 WIDTH SHALL be a positive multiple of CHUNK; N = WIDTH/CHUNK slices; any other value is a configuration error.
REQ-016 FSM states SHALL be IDLE, CALC and DONE.
REQ-017 in_ready SHALL be 1 only in IDLE; out_valid SHALL be 1 only in DONE.
REQ-018 IDLE -> CALC on in_valid & in_ready; a, b, b_i latched on that edge, slice index cleared to 0, running borrow loaded with b_i.
REQ-019 In CALC, each edge SHALL process slice k (bits k*CHUNK .. k*CHUNK+CHUNK-1) and write those d bits.
- per bit: g = ~a & b, p = ~(a ^ b), d = a ^ b ^ bin.
- borrows inside a slice SHALL be computed in lookahead form from g, p and the slice borrow-in, not rippled: bout = g | (p & bin) expanded to two-level sum-of-products.
- running borrow is updated to the slice borrow-out; the index increments.
REQ-020 After slice N-1, CALC -> DONE; b_o = final running borrow, zero = (d == 0), all registered.
REQ-021 Latency: out_valid SHALL rise exactly N cycles after the accepting edge (4 for default parameters).
REQ-022 DONE -> IDLE on out_ready; d, b_o and zero SHALL stay stable while out_valid & ~out_ready.
REQ-023 A new operand SHALL NOT be accepted in the cycle the result is taken; next accept is no earlier than the following cycle.
REQ-024 in_valid in CALC or DONE SHALL be ignored, and inputs SHALL NOT be sampled.
REQ-025 a and b changing during CALC SHALL NOT affect the result (latched copies only).
REQ-026 Boundary cases: a == b with b_i=0 gives d=0, b_o=0, zero=1; 0 - 0 with b_i=1 gives all-ones, b_o=1; WIDTH == CHUNK gives N=1, latency 1.

Reset
REQ-027 rst assertion SHALL immediately force IDLE, in_ready=1, out_valid=0, d=0, b_o=0, zero=0, slice index 0, running borrow 0.
REQ-028 rst during CALC or DONE SHALL discard the operation, and no out_valid SHALL follow for it.
REQ-029 The first accept after reset deassertion SHALL be possible on the first rising edge with rst low.

Verification
REQ-030 WIDTH=16, CHUNK=4: a=0x1234, b=0x0234, b_i=0 -> out_valid 4 cycles after accept, d=0x1000, b_o=0, zero=0.
REQ-031 a=0x0000, b=0x0001, b_i=0 -> d=0xFFFF, b_o=1, zero=0; borrow ripples across all four slices.
REQ-032 a=b=0xABCD, b_i=0 -> d=0x0000, b_o=0, zero=1; repeat with b_i=1 -> d=0xFFFF, b_o=1, zero=0.
REQ-033 Backpressure: out_ready low 5 cycles after out_valid -> outputs constant, in_ready 0, extra in_valid ignored; out_ready high -> IDLE next cycle.
REQ-034 Assert rst in the 2nd CALC cycle -> same cycle in_ready=1, out_valid=0, d=0; after release a fresh 0x8000-0x0001 -> d=0x7FFF, b_o=0.
REQ-035 Random: 1000 operand sets with random in_valid/out_ready -> every result equals the (a - b - b_i) mod 2^16 reference with the correct b_o, with no lost or duplicated transactions.

Source files
------------

// File: rtl/lookahead_borrow_subtractor.sv
// Multi-cycle subtractor: resolves CHUNK bits per cycle with a two-level
// borrow-lookahead slice, handing the running borrow from slice to slice.
module lookahead_borrow_subtractor #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             b_i,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] d,
  output logic             b_o,
  output logic             zero
);

  localparam int unsigned N    = (CHUNK == 0) ? 1 : WIDTH / CHUNK;
  localparam int unsigned IdxW = (N > 1) ? $clog2(N) : 1;

  if ((CHUNK == 0) || (WIDTH == 0) || ((WIDTH % CHUNK) != 0)) begin : gen_cfg_err
    $error("WIDTH must be a positive multiple of CHUNK");
  end

  typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, b_q, d_q;
  logic [IdxW-1:0]  idx_q;
  logic             borrow_q, b_o_q, zero_q;

  logic [CHUNK-1:0] a_sl, b_sl, g, p, d_sl;
  logic [CHUNK:0]   c;
  logic [WIDTH-1:0] slice_mask, d_next;
  logic             last;
  int unsigned      shamt;

  // Borrow out of bit 'top' as a flat OR of AND terms over g, p and the slice borrow-in.
  function automatic logic slice_borrow(input logic [CHUNK-1:0] g_v,
                                        input logic [CHUNK-1:0] p_v,
                                        input logic             bin,
                                        input int unsigned      top);
    logic acc, term;
    acc = 1'b0;
    for (int unsigned j = 0; j < CHUNK; j++) begin
      if (j <= top) begin
        term = g_v[j];
        for (int unsigned k = j + 1; k < CHUNK; k++) begin
          if (k <= top) term = term & p_v[k];
        end
        acc = acc | term;
      end
    end
    term = bin;
    for (int unsigned k = 0; k < CHUNK; k++) begin
      if (k <= top) term = term & p_v[k];
    end
    return acc | term;
  endfunction

  // Operand copies shift right each cycle, so the active slice is always the low CHUNK bits.
  always_comb begin
    shamt = 32'(idx_q) * CHUNK;
    a_sl  = a_q[CHUNK-1:0];
    b_sl  = b_q[CHUNK-1:0];
    g     = ~a_sl & b_sl;
    p     = ~(a_sl ^ b_sl);
    c     = '0;
    c[0]  = borrow_q;
    for (int unsigned i = 0; i < CHUNK; i++) begin
      c[i+1] = slice_borrow(g, p, borrow_q, i);
    end
    d_sl       = a_sl ^ b_sl ^ c[CHUNK-1:0];
    slice_mask = WIDTH'({CHUNK{1'b1}}) << shamt;
    d_next     = (d_q & ~slice_mask) | (WIDTH'(d_sl) << shamt);
    last       = (idx_q == IdxW'(N - 1));
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (in_valid)  state_d = StCalc;
      StCalc:  if (last)      state_d = StDone;
      StDone:  if (out_ready) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StIdle;
      a_q      <= '0;
      b_q      <= '0;
      d_q      <= '0;
      idx_q    <= '0;
      borrow_q <= 1'b0;
      b_o_q    <= 1'b0;
      zero_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if ((state_q == StIdle) && in_valid) begin
        a_q      <= a;
        b_q      <= b;
        borrow_q <= b_i;
        idx_q    <= '0;
      end
      if (state_q == StCalc) begin
        a_q      <= a_q >> CHUNK;
        b_q      <= b_q >> CHUNK;
        d_q      <= d_next;
        borrow_q <= c[CHUNK];
        idx_q    <= idx_q + IdxW'(1);
        if (last) begin
          b_o_q  <= c[CHUNK];
          zero_q <= (d_next == '0);
        end
      end
    end
  end

  assign in_ready  = (state_q == StIdle);
  assign out_valid = (state_q == StDone);
  assign d         = d_q;
  assign b_o       = b_o_q;
  assign zero      = zero_q;

endmodule

// File: tb/tb_lookahead_borrow_subtractor.sv
// Self-checking bench: directed boundary cases plus randomized handshaking
// against an arithmetic reference of a - b - b_i.
module tb_lookahead_borrow_subtractor;

  localparam int unsigned WIDTH = 16;
  localparam int unsigned CHUNK = 4;
  localparam int unsigned N     = WIDTH / CHUNK;
  localparam int unsigned NOPS  = 1000;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid, in_ready, out_valid, out_ready;
  logic [WIDTH-1:0] a, b, d;
  logic             b_i, b_o, zero;

  int checks   = 0;
  int failures = 0;

  lookahead_borrow_subtractor #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .a        (a),
    .b        (b),
    .b_i      (b_i),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .d        (d),
    .b_o      (b_o),
    .zero     (zero)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Returns {borrow, zero, difference}.
  function automatic logic [17:0] ref_sub(input logic [15:0] x, input logic [15:0] y,
                                          input logic bi);
    logic [16:0] diff;
    diff = {1'b0, x} - {1'b0, y} - {16'd0, bi};
    return {diff[16], diff[15:0] == 16'd0, diff[15:0]};
  endfunction

  // Starts at a negedge with the DUT idle; ends at a negedge with the DUT idle.
  task automatic run_op(input logic [15:0] x, input logic [15:0] y, input logic bi,
                        input string tag);
    logic [17:0] exp;
    int          lat;
    exp = ref_sub(x, y, bi);
    check_eq({tag, "_in_ready"}, in_ready, 1);
    a = x; b = y; b_i = bi; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0; a = 16'($urandom); b = 16'($urandom); b_i = 1'($urandom);
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    check_eq({tag, "_latency"}, lat, N);
    check_eq({tag, "_d"}, d, exp[15:0]);
    check_eq({tag, "_b_o"}, b_o, exp[17]);
    check_eq({tag, "_zero"}, zero, exp[16]);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check_eq({tag, "_idle_out_valid"}, out_valid, 0);
    check_eq({tag, "_idle_in_ready"}, in_ready, 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [17:0] exp;
    logic [17:0] q[$];
    int          acc_cnt, take_cnt, cyc, since, lat;
    bit          seen;

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; b_i = 1'b0;
    #2;
    check_eq("rst_in_ready", in_ready, 1);
    check_eq("rst_out_valid", out_valid, 0);
    check_eq("rst_d", d, 0);
    check_eq("rst_b_o", b_o, 0);
    check_eq("rst_zero", zero, 0);
    @(negedge clk);
    rst = 1'b0;

    // First accept lands on the first rising edge after reset release.
    run_op(16'h1234, 16'h0234, 1'b0, "basic");
    run_op(16'h0000, 16'h0001, 1'b0, "ripple");
    run_op(16'hABCD, 16'hABCD, 1'b0, "equal");
    run_op(16'hABCD, 16'hABCD, 1'b1, "equal_bi");
    run_op(16'h0000, 16'h0000, 1'b1, "zero_bi");

    // Backpressure: result must hold and extra in_valid must be ignored.
    exp = ref_sub(16'h5555, 16'h1234, 1'b1);
    a = 16'h5555; b = 16'h1234; b_i = 1'b1; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    check_eq("bp_latency", lat, N);
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; a = 16'($urandom); b = 16'($urandom); b_i = 1'($urandom);
      @(negedge clk);
      check_eq("bp_d", d, exp[15:0]);
      check_eq("bp_b_o", b_o, exp[17]);
      check_eq("bp_zero", zero, exp[16]);
      check_eq("bp_out_valid", out_valid, 1);
      check_eq("bp_in_ready", in_ready, 0);
    end
    // in_valid stays high through the take edge; nothing may be accepted there.
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0; in_valid = 1'b0;
    check_eq("bp_release_out_valid", out_valid, 0);
    check_eq("bp_release_in_ready", in_ready, 1);
    @(negedge clk);
    check_eq("bp_no_accept_in_ready", in_ready, 1);

    // Reset in the second CALC cycle discards the operation.
    a = 16'hFFFF; b = 16'h0F0F; b_i = 1'b0; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    check_eq("mid_rst_in_ready", in_ready, 1);
    check_eq("mid_rst_out_valid", out_valid, 0);
    check_eq("mid_rst_d", d, 0);
    @(negedge clk);
    rst = 1'b0;
    run_op(16'h8000, 16'h0001, 1'b0, "after_rst");

    // Randomized traffic with random handshakes.
    acc_cnt = 0; take_cnt = 0; cyc = 0; since = 0; seen = 1'b1;
    while ((acc_cnt < NOPS || q.size() != 0) && cyc < 60000) begin
      in_valid  = (acc_cnt < NOPS) ? 1'($urandom_range(0, 1)) : 1'b0;
      a         = 16'($urandom);
      b         = 16'($urandom);
      b_i       = 1'($urandom);
      out_ready = 1'($urandom_range(0, 1));
      #1;
      if (out_valid && !seen) begin
        // since counts negedges from the accepting one; the accept edge follows it.
        check_eq("rand_latency", since - 1, N);
        seen = 1'b1;
      end
      if (in_valid && in_ready) begin
        q.push_back(ref_sub(a, b, b_i));
        acc_cnt++;
        since = 0;
        seen  = 1'b0;
      end
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          check_eq("rand_spurious", 1, 0);
        end else begin
          exp = q.pop_front();
          check_eq("rand_d", d, exp[15:0]);
          check_eq("rand_b_o", b_o, exp[17]);
          check_eq("rand_zero", zero, exp[16]);
        end
        take_cnt++;
      end
      @(negedge clk);
      since++;
      cyc++;
    end
    in_valid = 1'b0; out_ready = 1'b0;
    check_eq("rand_accepts", acc_cnt, NOPS);
    check_eq("rand_takes", take_cnt, NOPS);
    check_eq("rand_pending", q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
